// File: rtl/pdp_pkg.sv
// Shared definitions for the pdp fetch/execute sequencer: opcodes,
// instruction field positions and the controller state type.
package pdp_pkg;

  localparam int INSTR_W = 16;

  // Instruction field bit positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes the sequencer itself reacts to; everything else is a plain ALU/memory op.
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_BEQ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } pdp_state_e;

endpackage

// File: rtl/pdp_step_edge.sv
// Step button conditioning: two-flop synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
module pdp_step_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the raw level and keep one cycle of history for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= step_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pdp_sequencer.sv
// Multi-cycle fetch/execute controller: FETCH -> LATCH -> EXEC per
// instruction, with BEQ/JMP/HALT handled here and a one-cycle commit strobe
// gating datapath writes. Optional breakpoint support is compiled in when
// PDP_BREAKPOINT_EN is defined.
//
// Instruction ROM interface: imem_rd_en is a one-cycle read request issued in
// FETCH with imem_addr = pc; the ROM has fixed one-cycle latency and no
// back-pressure, so imem_data is captured unconditionally at the end of LATCH.
module pdp_sequencer
  import pdp_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [15:0]        imem_data,
  output logic [15:0]        instr,
  input  logic               alu_zero,
  output logic               dp_commit,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
`ifdef PDP_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic               bp_hit,
`endif
  output pdp_state_e         dbg_state
);

  logic                step_edge;
  pdp_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pc_seq, pc_taken, pc_jmp;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [3:0]          opcode;
  logic [7:0]          imm;

  pdp_step_edge u_step_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .step_i (step),
    .edge_o (step_edge)
  );

  assign opcode   = instr_q[OPC_MSB:OPC_LSB];
  assign imm      = instr_q[IMM_MSB:IMM_LSB];
  // All PC arithmetic wraps modulo 2^PC_W; the branch offset is sign-extended.
  assign pc_seq   = pc_q + PC_W'(1);
  assign pc_taken = pc_seq + PC_W'(signed'(imm));
  assign pc_jmp   = instr_q[PC_W-1:0];

`ifdef PDP_BREAKPOINT_EN
  logic run_q;
  logic bp_hit_q, bp_hit_d;
  logic bp_set;
`endif

  // Next-state, PC, instruction latch, retire counter and commit strobe.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    dp_commit = 1'b0;
`ifdef PDP_BREAKPOINT_EN
    bp_set    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef PDP_BREAKPOINT_EN
        // A step edge always executes, which lets the user step off a breakpoint.
        if (step_edge) begin
          state_d = FETCH;
        end else if (run) begin
          if (bp_en && (pc_q == bp_addr)) bp_set = 1'b1;
          else                            state_d = FETCH;
        end
`else
        // run and a step edge together simply start one fetch; the edge is consumed.
        if (run || step_edge) state_d = FETCH;
`endif
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        instr_d = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          // BEQ/JMP also commit; the decoder has already masked their write enables.
          dp_commit = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          case (opcode)
            OP_BEQ:  pc_d = alu_zero ? pc_taken : pc_seq;
            OP_JMP:  pc_d = pc_jmp;
            default: pc_d = pc_seq;
          endcase
          state_d = run ? FETCH : IDLE;
`ifdef PDP_BREAKPOINT_EN
          if (run && bp_en && (pc_d == bp_addr)) begin
            state_d = IDLE;
            bp_set  = 1'b1;
          end
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Controller state and datapath-facing registers; reset aborts any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

`ifdef PDP_BREAKPOINT_EN
  // Sticky breakpoint flag: cleared by a step edge or a run rising edge, set wins.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (step_edge || (run && !run_q)) bp_hit_d = 1'b0;
    if (bp_set)                       bp_hit_d = 1'b1;
  end

  // Breakpoint flag and run history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      run_q    <= run;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`endif

  assign imem_rd_en = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign busy       = (state_q == FETCH) || (state_q == LATCH) || (state_q == EXEC);
  assign halted     = (state_q == HALT);
  assign retired    = retired_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pdp_sequencer.sv
// Testbench for pdp_sequencer: ROM model, commit scoreboard and
// per-scenario tasks. Breakpoint scenario compiles with PDP_BREAKPOINT_EN.
module tb_pdp_sequencer;
  import pdp_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst, run, step;
  logic              imem_rd_en;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [15:0]       instr;
  logic              alu_zero;
  logic              dp_commit;
  logic [PC_W-1:0]   pc;
  logic              busy, halted;
  logic [CNT_W-1:0]  retired;
  pdp_state_e        dbg_state;
`ifdef PDP_BREAKPOINT_EN
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic              bp_hit;
`endif

  logic [15:0]       rom [256];
  logic [PC_W+15:0]  exp_q[$];
  logic [PC_W+15:0]  exp_item;
  int unsigned       commit_cyc[$];
  int unsigned       cycle = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  pdp_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .alu_zero   (alu_zero),
    .dp_commit  (dp_commit),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired),
`ifdef PDP_BREAKPOINT_EN
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and synchronous one-cycle-latency ROM.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (imem_rd_en) imem_data <= rom[imem_addr];
  end

  // Scoreboard: every commit must match the next expected {pc, instr}.
  always @(negedge clk) begin
    if (dp_commit) begin
      commit_cyc.push_back(cycle);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: got pc=%h instr=%h, required no commit", pc, instr);
      end else begin
        exp_item = exp_q.pop_front();
        if ({pc, instr} !== exp_item) begin
          n_err++;
          $display("FAIL commit_trace: got pc=%h instr=%h, required pc=%h instr=%h",
                   pc, instr, exp_item[PC_W+15:16], exp_item[15:0]);
        end
      end
    end
  end

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = {OP_HALT, 12'h000};
  endtask

  task automatic load_alu_prog(input int n);
    fill_rom();
    for (int i = 0; i < n; i++) rom[i] = 16'h1000 | 16'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    exp_q.delete();
    commit_cyc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input pdp_state_e s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; run = 1'b0; step = 1'b0; alu_zero = 1'b0;
    #1;
    n_cmp++; if (pc !== 8'h00)        begin n_err++; $display("FAIL reset_pc: got %h, required 00", pc); end
    n_cmp++; if (instr !== 16'h0000)  begin n_err++; $display("FAIL reset_instr: got %h, required 0000", instr); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (halted !== 1'b0)     begin n_err++; $display("FAIL reset_halted: got %b, required 0", halted); end
    n_cmp++; if (retired !== 16'h0)   begin n_err++; $display("FAIL reset_retired: got %h, required 0000", retired); end
    n_cmp++; if (imem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b, required 0", imem_rd_en); end
    n_cmp++; if (dp_commit !== 1'b0)  begin n_err++; $display("FAIL reset_commit: got %b, required 0", dp_commit); end
    load_alu_prog(4);
    do_reset();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || dp_commit !== 1'b0 || dbg_state !== IDLE) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL idle_quiet: got activity while run=0, required none"); end
  endtask

  task automatic test_free_run();
    bit ok;
    load_alu_prog(3);
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back({PC_W'(i), 16'h1000 | 16'(i)});
    run = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00)
      begin n_err++; $display("FAIL first_fetch: got rd_en=%b addr=%h, required 1 00", imem_rd_en, imem_addr); end
    wait_state(HALT, 40, ok);
    run = 1'b0;
    n_cmp++; if (!ok)               begin n_err++; $display("FAIL run_timeout: got state %s, required HALT", dbg_state.name()); end
    n_cmp++; if (retired !== 16'd3) begin n_err++; $display("FAIL run_retired: got %0d, required 3", retired); end
    n_cmp++; if (pc !== 8'h03)      begin n_err++; $display("FAIL run_pc: got %h, required 03", pc); end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL run_halt_flags: got halted=%b busy=%b, required 1 0", halted, busy); end
    n_cmp++; if (commit_cyc.size() != 3) begin n_err++; $display("FAIL run_commits: got %0d, required 3", commit_cyc.size()); end
    else begin
      n_cmp++; if (commit_cyc[1] - commit_cyc[0] != 3 || commit_cyc[2] - commit_cyc[1] != 3)
        begin n_err++; $display("FAIL run_spacing: got %0d,%0d, required 3,3",
                                commit_cyc[1] - commit_cyc[0], commit_cyc[2] - commit_cyc[1]); end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (pc !== 8'h03 || dbg_state !== HALT)
      begin n_err++; $display("FAIL halt_frozen: got pc=%h state=%s, required 03 HALT", pc, dbg_state.name()); end
  endtask

  task automatic test_branch();
    logic [7:0]  tgt  [3] = '{8'h05, 8'h05, 8'hFE};
    logic [15:0] beq  [3] = '{16'hE0FD, 16'hE0FD, 16'hE005};
    logic        zero [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  expc [3] = '{8'h03, 8'h06, 8'h04};
    bit ok;
    for (int c = 0; c < 3; c++) begin
      fill_rom();
      rom[0]      = {OP_JMP, 4'h0, tgt[c]};
      rom[tgt[c]] = beq[c];
      alu_zero    = zero[c];
      do_reset();
      exp_q.push_back({8'h00, OP_JMP, 4'h0, tgt[c]});
      exp_q.push_back({tgt[c], beq[c]});
      run = 1'b1;
      wait_state(HALT, 40, ok);
      run = 1'b0;
      n_cmp++; if (!ok || pc !== expc[c])
        begin n_err++; $display("FAIL branch_pc[%0d]: got %h, required %h", c, pc, expc[c]); end
      n_cmp++; if (retired !== 16'd2 || exp_q.size() != 0)
        begin n_err++; $display("FAIL branch_retired[%0d]: got %0d pending=%0d, required 2 0", c, retired, exp_q.size()); end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_single_step();
    load_alu_prog(8);
    do_reset();
    exp_q.push_back({8'h00, 16'h1000});
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (retired !== 16'd1 || pc !== 8'h01 || dbg_state !== IDLE)
      begin n_err++; $display("FAIL step_one: got retired=%0d pc=%h state=%s, required 1 01 IDLE", retired, pc, dbg_state.name()); end
    // Second edge lands while the instruction is in flight and must be dropped.
    exp_q.push_back({8'h01, 16'h1001});
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    step = 1'b1;
    repeat (12) @(negedge clk);
    step = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (retired !== 16'd2 || pc !== 8'h02)
      begin n_err++; $display("FAIL step_busy_edge: got retired=%0d pc=%h, required 2 02", retired, pc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL step_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_run_drop();
    bit ok;
    load_alu_prog(8);
    do_reset();
    exp_q.push_back({8'h00, 16'h1000});
    run = 1'b1;
    wait_state(LATCH, 10, ok);
    run = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_latch_timeout: got %s, required LATCH", dbg_state.name()); end
    repeat (6) @(negedge clk);
    n_cmp++; if (retired !== 16'd1 || pc !== 8'h01 || dbg_state !== IDLE)
      begin n_err++; $display("FAIL drop_state: got retired=%0d pc=%h state=%s, required 1 01 IDLE", retired, pc, dbg_state.name()); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL drop_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_in_exec();
    bit ok;
    load_alu_prog(8);
    do_reset();
    exp_q.push_back({8'h00, 16'h1000});
    exp_q.push_back({8'h01, 16'h1001});
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dbg_state == LATCH && pc == 8'h02) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_exec_timeout: got pc=%h, required LATCH at 02", pc); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_state !== EXEC) begin n_err++; $display("FAIL rst_pre_state: got %s, required EXEC", dbg_state.name()); end
    rst = 1'b1; #1;
    n_cmp++; if (dp_commit !== 1'b0 || pc !== 8'h00)
      begin n_err++; $display("FAIL rst_abort: got commit=%b pc=%h, required 0 00", dp_commit, pc); end
    n_cmp++; if (dbg_state !== IDLE || busy !== 1'b0 || retired !== 16'd0)
      begin n_err++; $display("FAIL rst_abort_state: got state=%s busy=%b retired=%0d, required IDLE 0 0", dbg_state.name(), busy, retired); end
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0 || dbg_state !== IDLE)
      begin n_err++; $display("FAIL rst_after: got pending=%0d state=%s, required 0 IDLE", exp_q.size(), dbg_state.name()); end
  endtask

`ifdef PDP_BREAKPOINT_EN
  task automatic test_breakpoint();
    bit ok;
    load_alu_prog(8);
    do_reset();
    bp_en = 1'b1; bp_addr = 8'h02;
    exp_q.push_back({8'h00, 16'h1000});
    exp_q.push_back({8'h01, 16'h1001});
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bp_hit) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (!ok || dbg_state !== IDLE || pc !== 8'h02 || retired !== 16'd2)
      begin n_err++; $display("FAIL bp_stop: got hit=%b state=%s pc=%h retired=%0d, required 1 IDLE 02 2", bp_hit, dbg_state.name(), pc, retired); end
    run = 1'b0;
    exp_q.push_back({8'h02, 16'h1002});
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    n_cmp++; if (bp_hit !== 1'b0 || retired !== 16'd3 || pc !== 8'h03)
      begin n_err++; $display("FAIL bp_step: got hit=%b retired=%0d pc=%h, required 0 3 03", bp_hit, retired, pc); end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
`ifdef PDP_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    test_reset();
    test_free_run();
    test_branch();
    test_single_step();
    test_run_drop();
    test_reset_in_exec();
`ifdef PDP_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdp_sequencer.md
Name: pdp_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit MIPS-style datapath. Replaces the VIO-driven instruction and the push-button clock.
- Fetches 16-bit instructions from a synchronous instruction ROM and presents them to the instruction decoder.
- Issues a one-cycle commit strobe that gates register-file and data-memory writes.
- Handles BEQ/JMP/HALT opcodes using the ALU zero flag.

Parameters:
- PC_W, 8, program counter / instruction address width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level: free-run execution while high.
- step  in  1  level: rising edge requests exactly one instruction; edge detected internally.
- imem_rd_en  out  1  instruction ROM read enable.
- imem_addr  out  PC_W  instruction ROM address (= pc).
- imem_data  in  16  ROM data; valid the cycle after imem_rd_en.
- instr  out  16  registered instruction to the decoder.
- alu_zero  in  1  ALU zero flag (combinational from instr).
- dp_commit  out  1  one-cycle write strobe to reg_file/data_memory enables.
- pc  out  PC_W  current program counter.
- busy  out  1  high in FETCH, LATCH and EXEC.
- halted  out  1  high in HALT state.
- retired  out  CNT_W  count of committed instructions.

Behaviour:
- Reset (async, rst=1): state IDLE; pc=0; instr=16'h0000; dp_commit=0; imem_rd_en=0; busy=0; halted=0; retired=0; step edge register=0.
- States: IDLE, FETCH, LATCH, EXEC, HALT.
- IDLE: if run=1 or step rising edge -> FETCH. If both occur together, run wins and the step edge is consumed.
- FETCH: imem_rd_en=1, imem_addr=pc -> LATCH.
- LATCH: instr <= imem_data -> EXEC.
- EXEC: decode instr[15:12].
  - HALT (4'hF): no commit; -> HALT.
  - Otherwise dp_commit=1 for this single cycle; retired increments (wraps at 2^CNT_W).
  - BEQ (4'hE): if alu_zero=1, pc <= pc + 1 + sext(instr[7:0]); else pc <= pc + 1.
  - JMP (4'hD): pc <= instr[PC_W-1:0].
  - All other opcodes: pc <= pc + 1.
  - Next state: FETCH if run=1, else IDLE.
- BEQ and JMP still assert dp_commit. The decoder deasserts RegWrite/MemWrite for them, so the commit has no architectural side effect.
- Latency: 3 cycles per instruction in run mode, back-to-back. From IDLE, the first imem_rd_en occurs 1 cycle after the request.
- PC arithmetic is modulo 2^PC_W. 8'hFF + 1 = 8'h00; backward branches wrap the same way.
- run dropped mid-instruction: the current instruction completes, then IDLE. No partial commit.
- Step edges while busy are ignored and not queued.
- HALT: halted=1, busy=0, pc frozen at the HALT address. Exit only via rst.
- rst mid-instruction aborts immediately. No dp_commit is issued in the reset cycle.

Optional Feature:
- Macro: PDP_BREAKPOINT_EN.
- Defined: adds ports bp_en (in, 1), bp_addr (in, PC_W) and bp_hit (out, 1, sticky).
  - In IDLE→FETCH or EXEC→FETCH transitions under run, if bp_en=1 and the next pc == bp_addr, go to IDLE instead of FETCH and set bp_hit=1.
  - bp_hit clears on the next step edge or on a run rising edge.
  - A step edge always executes the instruction at bp_addr, so single-stepping past a breakpoint works.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Package pdp_pkg:
  - Opcode constants OP_BEQ=4'hE, OP_JMP=4'hD, OP_HALT=4'hF.
  - Enumerated state type (IDLE, FETCH, LATCH, EXEC, HALT).
  - Instruction field bit positions.
- One sub-module: pdp_step_edge (2-flop sync plus rising-edge pulse for step). Its reset is the same async rst.

Test Plan:
- Reset/idle: rst pulse with run=0 -> pc=0, busy=0, dp_commit never asserted over 20 cycles.
- Free-run: ROM[0..2] = 3 ALU ops, ROM[3] = HALT, run=1 -> dp_commit pulses every 3rd cycle (3 pulses), retired=3, halted=1, pc=3.
- Branch: ROM[5] = BEQ imm=8'hFD.
  - alu_zero=1 -> pc becomes 3.
  - alu_zero=0 -> pc becomes 6.
  - With pc=8'hFE and imm=8'h05 -> pc wraps to 8'h04.
- Single-step: run=0, step held high 10 cycles -> exactly one instruction, retired +1. A second edge while busy is ignored.
- Mid-operation: drop run during LATCH -> that instruction commits once, then IDLE. Assert rst during EXEC -> dp_commit low, pc=0 immediately.
- With PDP_BREAKPOINT_EN, bp_addr=2, run=1:
  - Stops in IDLE with pc=2, bp_hit=1, retired=2.
  - A step edge then executes ROM[2] and clears bp_hit.
